// File: rtl/inpacket_rx_pkg.sv
// ---------------------------------------------------------------------------
// inpacket_rx_pkg
// Definitions shared by the packet receiver and the UART byte receiver:
//   - rx_state_e   : framing FSM states (IDLE / RECEIVING)
//   - uart_state_e : UART bit-level FSM states
//   - CSUM_SEED    : initial value of the running XOR checksum
// Byte-order convention: data bytes travel most-significant byte first, so
// the first byte of a frame ends up in the top byte of the packet word.
// ---------------------------------------------------------------------------
package inpacket_rx_pkg;

   typedef enum logic {
      STATE_IDLE      = 1'b0,
      STATE_RECEIVING = 1'b1
   } rx_state_e;

   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_e;

   localparam logic [7:0] CSUM_SEED = 8'h00;

endpackage

// File: rtl/inpacket_rx_uart_rx.sv
// ---------------------------------------------------------------------------
// inpacket_rx_uart_rx
// 8N1 UART byte receiver, LSB first, sampling each bit at its centre.
// Ports:
//   i_Clk        : clock (rising edge)
//   i_Rst_n      : synchronous active-low reset, holds the receiver idle
//   i_RX_Serial  : serial line, idle high (asynchronous, synchronised here)
//   o_RX_DV      : one-cycle strobe, o_RX_Byte holds a new byte
//   o_RX_Byte    : last received byte
// ---------------------------------------------------------------------------
module inpacket_rx_uart_rx
   import inpacket_rx_pkg::*;
#(
   parameter int g_CLKS_PER_BIT = 50
) (
   input  logic       i_Clk,
   input  logic       i_Rst_n,
   input  logic       i_RX_Serial,
   output logic       o_RX_DV,
   output logic [7:0] o_RX_Byte
);

   localparam int CW = (g_CLKS_PER_BIT > 1) ? $clog2(g_CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] FULL_C = CW'(g_CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_C = CW'((g_CLKS_PER_BIT - 1) / 2);

   logic              rx_meta_q;
   logic              rx_sync_q;
   uart_state_e       state_q;
   logic [CW-1:0]     cnt_q;
   logic [2:0]        bit_q;
   logic [7:0]        byte_q;
   logic              dv_q;

   // Two-flop synchroniser; the line is asynchronous to clk.
   always_ff @(posedge i_Clk) begin
      rx_meta_q <= i_RX_Serial;
      rx_sync_q <= rx_meta_q;
   end

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
         state_q <= UART_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         dv_q    <= 1'b0;
      end else begin
         dv_q <= 1'b0;
         case (state_q)
            UART_IDLE: begin
               cnt_q <= '0;
               bit_q <= '0;
               if (!rx_sync_q) state_q <= UART_START;
            end
            // Re-check the start bit at its centre to reject glitches; from
            // here on every FULL_C count lands in the middle of a bit.
            UART_START: begin
               if (cnt_q == HALF_C) begin
                  cnt_q   <= '0;
                  state_q <= rx_sync_q ? UART_IDLE : UART_DATA;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            UART_DATA: begin
               if (cnt_q == FULL_C) begin
                  cnt_q  <= '0;
                  byte_q <= {rx_sync_q, byte_q[7:1]};
                  bit_q  <= bit_q + 1'b1;
                  if (bit_q == 3'd7) state_q <= UART_STOP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            // Byte is released at the centre of the stop bit, leaving half a
            // bit of margin before a back-to-back start bit.
            UART_STOP: begin
               if (cnt_q == FULL_C) begin
                  cnt_q   <= '0;
                  dv_q    <= rx_sync_q;
                  state_q <= UART_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= UART_IDLE;
         endcase
      end
   end

   assign o_RX_DV   = dv_q;
   assign o_RX_Byte = byte_q;

endmodule

// File: rtl/inpacket_rx.sv
// ---------------------------------------------------------------------------
// inpacket_rx
// Serial packet receiver: collects BYTES data bytes plus one XOR checksum
// byte from a UART stream and presents each good packet on a parallel bus.
// An inter-byte idle timeout drops partial frames to regain framing.
// Ports:
//   clk          : clock (rising edge)
//   rst_n        : synchronous active-low reset
//   rx           : serial line, idle high
//   packetData   : last good packet, first received byte in the top byte
//   packetValid  : one-cycle pulse, packetData updated this cycle
//   csumError    : one-cycle pulse, complete frame with bad checksum
//   timeoutError : one-cycle pulse, partial frame discarded on timeout
// ---------------------------------------------------------------------------
module inpacket_rx
   import inpacket_rx_pkg::*;
#(
   parameter int CLKDIVIDER  = 50,
   parameter int BYTES       = 4,
   parameter int COUNTERBITS = 3,
   parameter int TIMEOUT     = 1000,
   parameter int TIMEOUTBITS = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rx,
   output logic [BYTES*8-1:0] packetData,
   output logic               packetValid,
   output logic               csumError,
   output logic               timeoutError
);

   localparam logic [COUNTERBITS-1:0] BYTES_C   = COUNTERBITS'(BYTES);
   localparam logic [TIMEOUTBITS-1:0] TIMEOUT_C = TIMEOUTBITS'(TIMEOUT - 1);

   logic                   rx_dv;
   logic [7:0]             rx_byte;

   rx_state_e              state_q;
   logic [COUNTERBITS-1:0] idx_q;
   logic [BYTES*8-1:0]     sreg_q;
   logic [BYTES*8-1:0]     sreg_d;
   logic [7:0]             csum_q;
   logic [7:0]             csum_d;
   logic [TIMEOUTBITS-1:0] timer_q;
   logic [BYTES*8-1:0]     data_q;
   logic                   valid_q;
   logic                   csum_err_q;
   logic                   tmo_err_q;

   inpacket_rx_uart_rx #(
      .g_CLKS_PER_BIT(CLKDIVIDER)
   ) u_uart_rx (
      .i_Clk       (clk),
      .i_Rst_n     (rst_n),
      .i_RX_Serial (rx),
      .o_RX_DV     (rx_dv),
      .o_RX_Byte   (rx_byte)
   );

   // New bytes enter at the bottom, so the first byte of the frame ends up
   // in the top byte once BYTES bytes have been shifted in.
   generate
      if (BYTES == 1) begin : g_sreg_one
         assign sreg_d = rx_byte;
      end else begin : g_sreg_many
         assign sreg_d = {sreg_q[BYTES*8-9:0], rx_byte};
      end
   endgenerate

   // The first byte of a frame restarts the checksum from the seed.
   assign csum_d = ((state_q == STATE_IDLE) ? CSUM_SEED : csum_q) ^ rx_byte;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= STATE_IDLE;
         idx_q      <= '0;
         sreg_q     <= '0;
         csum_q     <= CSUM_SEED;
         timer_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         csum_err_q <= 1'b0;
         tmo_err_q  <= 1'b0;
      end else begin
         valid_q    <= 1'b0;
         csum_err_q <= 1'b0;
         tmo_err_q  <= 1'b0;
         case (state_q)
            STATE_IDLE: begin
               timer_q <= '0;
               if (rx_dv) begin
                  sreg_q  <= sreg_d;
                  csum_q  <= csum_d;
                  idx_q   <= COUNTERBITS'(1);
                  state_q <= STATE_RECEIVING;
               end
            end
            STATE_RECEIVING: begin
               // A byte arriving together with timer expiry is accepted.
               if (rx_dv) begin
                  timer_q <= '0;
                  if (idx_q == BYTES_C) begin
                     if (rx_byte == csum_q) begin
                        data_q  <= sreg_q;
                        valid_q <= 1'b1;
                     end else begin
                        csum_err_q <= 1'b1;
                     end
                     idx_q   <= '0;
                     state_q <= STATE_IDLE;
                  end else begin
                     sreg_q <= sreg_d;
                     csum_q <= csum_d;
                     idx_q  <= idx_q + 1'b1;
                  end
               end else if (timer_q == TIMEOUT_C) begin
                  tmo_err_q <= 1'b1;
                  timer_q   <= '0;
                  idx_q     <= '0;
                  csum_q    <= CSUM_SEED;
                  state_q   <= STATE_IDLE;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            default: state_q <= STATE_IDLE;
         endcase
      end
   end

   assign packetData   = data_q;
   assign packetValid  = valid_q;
   assign csumError    = csum_err_q;
   assign timeoutError = tmo_err_q;

endmodule

// File: tb/tb_inpacket_rx.sv
module tb_inpacket_rx;

   localparam int CLKDIV  = 50;
   localparam int NB      = 4;
   localparam int TMO     = 1000;
   localparam int SETTLE  = TMO + 300;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      int          kind;   // 0 = good packet, 1 = checksum error, 2 = timeout
      logic [31:0] data;
   } ev_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              rx = 1'b1;
   logic [NB*8-1:0]   packetData;
   logic              packetValid;
   logic              csumError;
   logic              timeoutError;

   int total = 0;
   int bad   = 0;

   ev_t         exp_q[$];
   ev_t         obs_q[$];
   logic [31:0] exp_data = '0;

   int          viol_stable = 0;
   int          viol_width  = 0;
   logic [31:0] prev_pd;
   logic        prev_v = 1'b0, prev_c = 1'b0, prev_t = 1'b0;

   inpacket_rx #(
      .CLKDIVIDER  (CLKDIV),
      .BYTES       (NB),
      .COUNTERBITS (3),
      .TIMEOUT     (TMO),
      .TIMEOUTBITS (10)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx           (rx),
      .packetData   (packetData),
      .packetValid  (packetValid),
      .csumError    (csumError),
      .timeoutError (timeoutError)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Output monitor: records every pulse and watches stability / pulse width.
   always @(negedge clk) begin
      if (rst_n) begin
         if (packetValid === 1'b1) obs_q.push_back('{0, packetData});
         if (csumError === 1'b1)   obs_q.push_back('{1, 32'h0});
         if (timeoutError === 1'b1) obs_q.push_back('{2, 32'h0});
         if (packetData !== prev_pd && packetValid !== 1'b1) viol_stable++;
         if ((packetValid === 1'b1 && prev_v) || (csumError === 1'b1 && prev_c) ||
             (timeoutError === 1'b1 && prev_t)) viol_width++;
      end
      prev_pd = packetData;
      prev_v  = (packetValid === 1'b1);
      prev_c  = (csumError === 1'b1);
      prev_t  = (timeoutError === 1'b1);
   end

   // Reference model: what a frame of these bytes should produce.
   function automatic void predict(input bq_t fr);
      logic [7:0]  x;
      logic [31:0] d;
      x = 8'h00;
      d = '0;
      if (fr.size() == NB + 1) begin
         for (int i = 0; i < NB; i++) begin
            x = x ^ fr[i];
            d = (d << 8) | 32'(fr[i]);
         end
         if (fr[NB] == x) begin
            exp_q.push_back('{0, d});
            exp_data = d;
         end else begin
            exp_q.push_back('{1, 32'h0});
         end
      end else begin
         exp_q.push_back('{2, 32'h0});
      end
   endfunction

   function automatic bq_t make_frame(input logic [31:0] d, input logic [7:0] corrupt);
      bq_t         fr;
      logic [7:0]  x;
      x = 8'h00;
      for (int i = NB - 1; i >= 0; i--) begin
         fr.push_back(d[i*8 +: 8]);
         x = x ^ d[i*8 +: 8];
      end
      fr.push_back(x ^ corrupt);
      return fr;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      rx = 1'b0;
      repeat (CLKDIV) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CLKDIV) @(posedge clk);
      end
      rx = 1'b1;
      repeat (CLKDIV) @(posedge clk);
   endtask

   task automatic send(input bq_t fr);
      for (int i = 0; i < fr.size(); i++) send_byte(fr[i]);
      predict(fr);
   endtask

   task automatic compare(input string tag);
      int n;
      repeat (SETTLE) @(posedge clk);
      @(negedge clk);
      chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk({tag, "_kind"}, 64'(obs_q[i].kind), 64'(exp_q[i].kind));
         if (exp_q[i].kind == 0) chk({tag, "_data"}, 64'(obs_q[i].data), 64'(exp_q[i].data));
      end
      chk({tag, "_held"}, 64'(packetData), 64'(exp_data));
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      bq_t fr;
      int  kind, len;
      logic [7:0] c;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_data", 64'(packetData), 64'h0);
      chk("rst_valid", 64'(packetValid), 64'h0);
      chk("rst_csum", 64'(csumError), 64'h0);
      chk("rst_tmo", 64'(timeoutError), 64'h0);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);

      // Good frame
      fr = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
      send(fr);
      compare("good");

      // Bad checksum keeps previous data
      fr = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};
      send(fr);
      compare("badcsum");

      // Truncated frame, then a good frame
      fr = '{8'hDE, 8'hAD};
      send(fr);
      compare("trunc");
      fr = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
      send(fr);
      compare("after_trunc");

      // Trailing byte after a good frame
      send(make_frame(32'hCAFE0123, 8'h00));
      fr = '{8'h00};
      send(fr);
      compare("trailing");
      send(make_frame(32'h5A5AA5A5, 8'h00));
      compare("after_trailing");

      // Reset mid-frame
      send_byte(8'h11);
      send_byte(8'h22);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("midrst_data", 64'(packetData), 64'h0);
      chk("midrst_valid", 64'(packetValid), 64'h0);
      chk("midrst_csum", 64'(csumError), 64'h0);
      chk("midrst_tmo", 64'(timeoutError), 64'h0);
      exp_data = '0;
      rst_n = 1'b1;
      compare("midrst_quiet");
      send(make_frame(32'h76543210, 8'h00));
      compare("after_rst");

      // Back-to-back frames, no gap
      send(make_frame(32'h13579BDF, 8'h00));
      send(make_frame(32'h2468ACE0, 8'h00));
      compare("b2b");

      // Randomised frames
      for (int k = 0; k < 6; k++) begin
         kind = $urandom_range(0, 3);
         if (kind == 3) begin
            len = $urandom_range(1, NB);
            fr.delete();
            for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
            send(fr);
         end else begin
            c = (kind == 2) ? 8'($urandom_range(1, 255)) : 8'h00;
            send(make_frame($urandom, c));
         end
         compare("rand");
      end

      chk("data_stable", 64'(viol_stable), 64'h0);
      chk("pulse_width", 64'(viol_width), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/inpacket_rx.md
# inpacket_rx

Serial packet receiver: deserialises a UART byte stream into fixed-length packets of BYTES data bytes plus one XOR checksum byte, checks the checksum, and presents each good packet on a parallel bus with a one-cycle valid strobe. It sits at the far end of the serial link, directly downstream of the packet transmitter. Its frame format is bit-compatible with that transmitter:
- data bytes are sent most-significant byte first;
- the last byte is the XOR of all data bytes.

An inter-byte idle timeout resynchronises framing after noise, truncated frames or trailing bytes.

## Interface
- CLKDIVIDER, 50: clocks per UART bit; passed to the UART_RX instance.
- BYTES, 4: data bytes per packet. Range 1..2^COUNTERBITS-1.
- COUNTERBITS, 3: width of the byte index.
- TIMEOUT, 1000: idle clocks after the last received byte before a partial frame is discarded. Must exceed one byte time (10*CLKDIVIDER).
- TIMEOUTBITS, 10: width of the timeout counter. Must satisfy 2^TIMEOUTBITS > TIMEOUT.
- clk  input  1: sole clock; all logic on the rising edge.
- rst_n  input  1: reset, synchronous and active-low.
- rx  input  1: serial line; idle high.
- packetData  output  BYTES*8: last good packet; first received byte in bits [BYTES*8-1 -: 8].
- packetValid  output  1: one-cycle pulse; packetData was updated this cycle.
- csumError  output  1: one-cycle pulse; a complete frame was received but its checksum mismatched.
- timeoutError  output  1: one-cycle pulse; a partial frame was discarded because of the timeout.

## Operation
- The UART_RX instance produces rxDv (a one-cycle pulse) and rxByte.
- Internal state:
  - state: IDLE or RECEIVING;
  - idx, COUNTERBITS wide;
  - shift register sreg, BYTES*8 wide;
  - running XOR csum, 8 bits;
  - timer, TIMEOUTBITS wide.
- IDLE:
  - On rxDv: sreg <= {sreg, rxByte}, csum <= rxByte, idx <= 1, timer <= 0, go to RECEIVING.
  - If BYTES==1, that byte completes the data field.
- RECEIVING, on rxDv with idx < BYTES: shift rxByte into sreg, csum <= csum ^ rxByte, idx <= idx+1, timer <= 0.
- RECEIVING, on rxDv with idx == BYTES (checksum byte):
  - If rxByte == csum: packetData <= sreg and pulse packetValid.
  - Otherwise: pulse csumError and leave packetData unchanged.
  - In both cases go to IDLE.
- RECEIVING, no rxDv:
  - timer increments.
  - When timer reaches TIMEOUT-1: pulse timeoutError, go to IDLE, discard sreg/csum.
- Simultaneous rxDv and timer expiry: rxDv wins; the byte is accepted and the timer clears.
- Any byte arriving in IDLE starts a new frame, including a stray trailing byte. That frame is discarded later by the timeout.
- Arithmetic: csum is a bitwise XOR in 8 bits with no carry. idx never exceeds BYTES.

## Timing
- Reset values, applied on the first rising clk edge with rst_n low:
  - packetData = 0; packetValid, csumError, timeoutError = 0;
  - state = IDLE, idx = 0, csum = 8'h00, timer = 0.
  - The UART_RX instance is held idle.
- Reset asserted mid-frame: the partial frame is lost and no error pulse is produced.
- Latency: packetValid, csumError and timeoutError are registered. Each is high in the cycle after the rxDv (or timer expiry) that caused it, for exactly one cycle.
- packetData changes only in the cycle packetValid is high, and is stable otherwise.
- No backpressure: the consumer must sample on packetValid. Packets arrive at least (BYTES+1)*10*CLKDIVIDER clocks apart.

## Structure
- Shared header packet_defs.vh, common with the packet transmitter, holds:
  - STATE_IDLE and STATE_SENDING/STATE_RECEIVING encodings;
  - checksum seed 8'h00;
  - byte-order convention (MSB-first).
- One sub-module: the existing UART_RX (g_CLKS_PER_BIT=CLKDIVIDER; ports i_Clk, i_RX_Serial, o_RX_DV, o_RX_Byte).
- Framing FSM, shift register, checksum and timer live in inpacket_rx.

## Test plan
- Good frame: serialise DE AD BE EF 22 with CLKDIVIDER=50. Expect one packetValid with packetData = 32'hDEADBEEF and no error pulses.
- Bad checksum: DE AD BE EF 23 -> csumError pulse; packetData keeps its previous value; no packetValid.
- Truncated frame: DE AD, then idle for 1000+ clocks -> timeoutError pulse. A following good frame 01 02 03 04 04 -> packetData = 32'h01020304.
- Trailing byte: good frame, then one extra byte 00, then idle -> packetValid once, then timeoutError once. A subsequent good frame is still received correctly.
- Reset mid-frame: pull rst_n low for 2 clocks after the second byte. Expect all outputs 0 and no error pulse. A fresh good frame afterwards is accepted.
- Back-to-back: two good frames with zero inter-frame gap -> two packetValid pulses carrying the correct data.
